// File: rtl/mmio_initiator.sv
// Bus-master end of the word-addressed MMIO/memory port: one byte-addressed
// load/store per handshake, lane steering on stores, align/extend on loads.
module mmio_initiator #(
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [3:0]            byteena,
    output logic                  clken,
    output logic [31:0]           data,
    output logic                  wren,
    input  logic [31:0]           q
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam int CW = $clog2(READ_LATENCY + 1);

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  write_q, write_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_error_q, resp_error_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [3:0]            byteena_q, byteena_d;
    logic                  clken_q, clken_d;
    logic [31:0]           data_q, data_d;
    logic                  wren_q, wren_d;

    logic                  illegal;
    logic [3:0]            be_dec;
    logic [31:0]           wdata_dec;
    logic [31:0]           q_shift;
    logic [31:0]           load_ext;

    always_comb begin
        illegal = (req_size == 2'd3) ||
                  (req_size == 2'd1 && req_addr[0]) ||
                  (req_size == 2'd2 && req_addr[1:0] != 2'd0);
        case (req_size)
            2'd0:    begin be_dec = 4'b0001 << req_addr[1:0]; wdata_dec = {4{req_wdata[7:0]}}; end
            2'd1:    begin be_dec = req_addr[1] ? 4'b1100 : 4'b0011; wdata_dec = {2{req_wdata[15:0]}}; end
            default: begin be_dec = 4'b1111; wdata_dec = req_wdata; end
        endcase
    end

    always_comb begin
        q_shift = q >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_ext = uns_q ? {24'd0, q_shift[7:0]} : {{24{q_shift[7]}}, q_shift[7:0]};
            2'd1:    load_ext = uns_q ? {16'd0, q_shift[15:0]} : {{16{q_shift[15]}}, q_shift[15:0]};
            default: load_ext = q_shift;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        write_d      = write_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        address_d    = address_q;
        byteena_d    = byteena_q;
        data_d       = data_q;
        clken_d      = 1'b0;
        wren_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    off_d       = req_addr[1:0];
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    write_d     = req_write;
                    req_ready_d = 1'b0;
                    if (illegal) begin
                        // Rejected requests answer directly and never touch the bus.
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = S_RESP;
                    end else begin
                        clken_d   = 1'b1;
                        wren_d    = req_write;
                        address_d = req_addr[ADDR_WIDTH+1:2];
                        byteena_d = be_dec;
                        data_d    = wdata_dec;
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (write_q) begin
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = '0;
                    state_d      = S_RESP;
                end else begin
                    cnt_d   = CW'(READ_LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = load_ext;
                    state_d      = S_RESP;
                end
            end
            default: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            write_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            address_q    <= '0;
            byteena_q    <= '0;
            clken_q      <= 1'b0;
            data_q       <= '0;
            wren_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            write_q      <= write_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            address_q    <= address_d;
            byteena_q    <= byteena_d;
            clken_q      <= clken_d;
            data_q       <= data_d;
            wren_q       <= wren_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;
    assign address    = address_q;
    assign byteena    = byteena_q;
    assign clken      = clken_q;
    assign data       = data_q;
    assign wren       = wren_q;
endmodule

// File: doc/mmio_initiator.md
Name: mmio_initiator

Overview:
- Bus-master end of the word-addressed MMIO/memory port (address, byteena, clken, data, wren, q).
- Sits between the core's load/store stage and any MMIO/RAM responder on that port.
- Accepts one byte-addressed load/store request at a time over a valid/ready handshake and issues a single registered bus cycle.
- Byte-lane steers store data; aligns and sign/zero-extends load data; reports misaligned or illegal accesses as errors without touching the bus.

Parameters:
- ADDR_WIDTH, 14, word-address width on the bus side; request address is ADDR_WIDTH+2 bits.
- READ_LATENCY, 1, cycles from the clken cycle until the responder's q is valid (>=1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  initiator can accept a request (high only in IDLE).
- req_addr  input  ADDR_WIDTH+2  byte address.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  input  32  store data, LSB-justified.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  misaligned or illegal size.
- address  output  ADDR_WIDTH  bus word address.
- byteena  output  4  bus byte enables.
- clken  output  1  bus cycle strobe.
- data  output  32  bus write data.
- wren  output  1  bus write enable.
- q  input  32  bus read data.

Behaviour:
- All outputs are registered.
- On reset assertion, every output goes to 0 immediately, except req_ready, which is 1. The FSM enters IDLE.
- Reset mid-transaction aborts the transaction with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture the request and decode it:
    - illegal request -> RESP with resp_error=1, resp_rdata=0, no bus cycle.
    - otherwise -> ISSUE.
- Illegal request: req_size=3; size 1 with addr[0]=1; size 2 with addr[1:0]!=0.
- ISSUE (exactly 1 cycle):
  - clken=1, wren=req_write.
  - address=req_addr[ADDR_WIDTH+1:2].
  - byteena and data drive the decoded values.
  - Next state: store -> RESP (resp_rdata=0, resp_error=0); load -> WAIT with counter=READ_LATENCY.
- WAIT:
  - clken=0, wren=0.
  - Counter decrements each cycle.
  - At the end of the cycle where the counter is 1, q is sampled, aligned and extended into resp_rdata -> RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_error are held stable.
  - When resp_ready=1: resp_valid drops next cycle -> IDLE.
  - req_ready stays 0 until IDLE; no request overlap.
- Outside ISSUE: clken=0 and wren=0; address, byteena and data hold their last values.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- Store data replication:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load data: shift q right by 8*addr[1:0], then truncate to 8/16/32 bits and extend per req_unsigned.
- Latency with READ_LATENCY=1, counting from the accept edge:
  - load: ISSUE in cycle 1, WAIT in cycle 2, resp_valid in cycle 3.
  - store: ISSUE in cycle 1, resp_valid in cycle 2.
  - error: resp_valid in cycle 1.
- Back-to-back requests: the minimum issue interval is one IDLE cycle between transactions.
- Request inputs are ignored outside IDLE.

Test Plan:
- Word store, byte addr 0x0004, wdata 0x12345678 → one ISSUE cycle with address=1, byteena=1111, data=0x12345678, wren=1, clken=1; resp_valid next cycle with rdata=0, error=0.
- Byte load, addr 0x0003, signed, q=0x80AABBCC → byteena=1000 in ISSUE; resp_rdata=0xFFFFFF80 in cycle 3 after accept.
  - Same request with req_unsigned=1 → 0x00000080.
- Half store, addr 0x0002, wdata 0x0000BEEF → byteena=1100, data=0xBEEFBEEF.
  - Half load, addr 0x0002, unsigned, q=0xBEEF0000 → 0x0000BEEF.
- Misaligned word load, addr 0x0006; size=3 request → no clken pulse; resp_valid the cycle after accept with error=1, rdata=0.
- Hold resp_ready=0 for 5 cycles → resp_valid and resp_rdata stable, req_ready=0, no clken.
  - resp_ready=1 → IDLE next cycle; a queued request is accepted there.
- Assert reset during WAIT → clken, wren and resp_valid are 0 immediately, req_ready=1, and no response is emitted.
  - READ_LATENCY=3 load → q is sampled 3 cycles after ISSUE.
